// File: rtl/eth_st_ta_pkg.sv
// ---------------------------------------------------------------------------
// eth_st_ta_pkg
// Shared definitions for the Ethernet streaming ready-latency timing adapter:
//   MAX_READY_LATENCY - largest upstream ready latency the adapter absorbs
//   DEFAULT_DATA_W    - default beat payload width
//   fifo_op_e         - per-cycle buffer operation (write/read combination)
//   clog2()           - ceiling log2 used to size pointers and counters
// ---------------------------------------------------------------------------
package eth_st_ta_pkg;

  localparam int unsigned MAX_READY_LATENCY = 32'd4;
  localparam int unsigned DEFAULT_DATA_W    = 32'd72;

  // Encoding is {write, read} so the operation can be cast straight from
  // the two qualified enables.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 32'd0;
    span   = 32'd1;
    while (span < value) begin
      span   = span << 1;
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/eth_st_ta_fifo.sv
// ---------------------------------------------------------------------------
// eth_st_ta_fifo
// First-word-fall-through buffer: register array with wrapping read/write
// pointers and an entry counter. The head entry is always presented on
// rd_data straight from storage.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   wr_en        - request to store wr_data (ignored when full unless a read
//                  frees the slot in the same cycle)
//   wr_data      - payload to store
//   rd_en        - request to pop the head (ignored when empty)
//   rd_data      - head entry
//   count        - registered entry count
//   count_next   - entry count after the current edge
//   full, empty  - decoded from the registered count
// ---------------------------------------------------------------------------
module eth_st_ta_fifo
  import eth_st_ta_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 32'd8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic [clog2(DEPTH):0]   count_next,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 32'd1;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              full_s;
  logic              empty_s;
  logic              do_wr_s;
  logic              do_rd_s;
  fifo_op_e          op_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);
  assign do_rd_s = rd_en & ~empty_s;
  // A write at full is only legal when the head leaves in the same cycle;
  // the tail slot then equals the departing head slot.
  assign do_wr_s = wr_en & (~full_s | do_rd_s);
  assign op_s    = fifo_op_e'({do_wr_s, do_rd_s});

  // Payload storage: written at the tail, deliberately never cleared.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Next entry count from the operation taking place this cycle.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      OP_WRITE: count_nxt_s = count_r + CNT_ONE;
      OP_READ:  count_nxt_s = count_r - CNT_ONE;
      OP_BOTH:  count_nxt_s = count_r;
      OP_IDLE:  count_nxt_s = count_r;
      default:  count_nxt_s = count_r;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  assign rd_data    = mem_r[rd_ptr_r];
  assign count      = count_r;
  assign count_next = count_nxt_s;
  assign full       = full_s;
  assign empty      = empty_s;

endmodule

// File: rtl/eth_st_rl_timing_adapter.sv
// ---------------------------------------------------------------------------
// eth_st_rl_timing_adapter
// Converts an upstream Avalon-ST-style interface with ready latency
// IN_READY_LATENCY (0..4) into a downstream ready-latency-0 interface.
// Beats pass through a FWFT buffer; in_ready is deasserted early enough
// that every beat a compliant upstream still has in flight finds a slot.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_ready              - backpressure to upstream (registered)
//   in_valid, in_data     - upstream beat
//   out_ready             - downstream ready (latency 0)
//   out_valid, out_data   - downstream beat, head of buffer
//   occupancy             - current number of buffered beats
//   overflow              - sticky: a beat arrived while the buffer was full
// ---------------------------------------------------------------------------
module eth_st_rl_timing_adapter
  import eth_st_ta_pkg::*;
#(
  parameter int unsigned DATA_W           = DEFAULT_DATA_W,
  parameter int unsigned IN_READY_LATENCY = 32'd0,
  parameter int unsigned FIFO_DEPTH       = 32'd8
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         in_ready,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [clog2(FIFO_DEPTH):0]   occupancy,
  output logic                         overflow
);

  localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 32'd1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // Highest occupancy at which upstream may still be granted: the
  // IN_READY_LATENCY beats already in flight must all fit.
  localparam logic [CNT_W-1:0] READY_MAX_C =
    CNT_W'(FIFO_DEPTH - 32'd1 - IN_READY_LATENCY);
  localparam logic ZERO_LATENCY = (IN_READY_LATENCY == 32'd0);

  if (IN_READY_LATENCY > MAX_READY_LATENCY) begin : g_bad_latency
    $error("eth_st_rl_timing_adapter: IN_READY_LATENCY %0d exceeds %0d",
           IN_READY_LATENCY, MAX_READY_LATENCY);
  end
  if ((FIFO_DEPTH < 32'd2) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0))
  begin : g_bad_depth_pow2
    $error("eth_st_rl_timing_adapter: FIFO_DEPTH %0d is not a power of two >= 2",
           FIFO_DEPTH);
  end
  if (FIFO_DEPTH < IN_READY_LATENCY + 32'd2) begin : g_bad_depth_small
    $error("eth_st_rl_timing_adapter: FIFO_DEPTH %0d too small for latency %0d",
           FIFO_DEPTH, IN_READY_LATENCY);
  end

  logic              in_ready_r;
  logic              out_valid_r;
  logic              overflow_r;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] rd_data_s;

  assign rd_en_s = ~empty_s & out_ready;

  // Write acceptance: with zero latency the handshake is in_valid & in_ready;
  // otherwise in_valid alone is binding and only a full buffer refuses it.
  always_comb begin
    wr_en_s = 1'b0;
    drop_s  = 1'b0;
    if (ZERO_LATENCY) begin
      wr_en_s = in_valid & in_ready_r;
      drop_s  = 1'b0;
    end else begin
      wr_en_s = in_valid & (~full_s | rd_en_s);
      drop_s  = in_valid & full_s & ~rd_en_s;
    end
  end

  eth_st_ta_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en_s),
    .wr_data    (in_data),
    .rd_en      (rd_en_s),
    .rd_data    (rd_data_s),
    .count      (count_s),
    .count_next (count_nxt_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Registered handshake outputs; each equals a decode of the count that the
  // buffer holds in the same cycle, and both are held low for the cycle
  // following a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (count_nxt_s <= READY_MAX_C);
      out_valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = rd_data_s;
  assign occupancy = count_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_eth_st_rl_timing_adapter.sv
`timescale 1ns/1ps
module tb_eth_st_rl_timing_adapter;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int N_INST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic [N_INST-1:0]          iv_v;
  logic [N_INST-1:0]          ir_v;
  logic [N_INST-1:0]          ordy_v;
  logic [N_INST-1:0]          ov_v;
  logic [N_INST-1:0]          ovf_v;
  logic [N_INST-1:0][DW-1:0]  id_v;
  logic [N_INST-1:0][DW-1:0]  od_v;
  logic [N_INST-1:0][3:0]     occ_v;

  // Instances 0..3 use ready latencies 0, 1, 2, 4.
  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    eth_st_rl_timing_adapter #(
      .DATA_W           (DW),
      .IN_READY_LATENCY ((g == 3) ? 4 : g),
      .FIFO_DEPTH       (DEPTH)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_ready  (ir_v[g]),
      .in_valid  (iv_v[g]),
      .in_data   (id_v[g]),
      .out_ready (ordy_v[g]),
      .out_valid (ov_v[g]),
      .out_data  (od_v[g]),
      .occupancy (occ_v[g]),
      .overflow  (ovf_v[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [3:0]    e_occ;
    logic          e_ir;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[12];

  function automatic int rl_of(input int k);
    return (k == 3) ? 4 : k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iv_v   = '0;
    ordy_v = '0;
    id_v   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < N_INST; k++) begin
      chk("rst_occ", occ_v[k], 0);
      chk("rst_out_valid", ov_v[k], 0);
      chk("rst_in_ready", ir_v[k], 0);
      chk("rst_overflow", ovf_v[k], 0);
    end
    reset = 1'b0;
    step();
    for (int k = 0; k < N_INST; k++) begin
      chk("post_rst_in_ready", ir_v[k], 1);
      chk("post_rst_out_valid", ov_v[k], 0);
      chk("post_rst_occ", occ_v[k], 0);
    end
  endtask

  // Randomised traffic against a queue model of the FIFO rules.
  task automatic run_random(input int k, input int n_beats);
    logic [DW-1:0] mq[$];
    bit            hist[5];
    bit            m_ovf;
    bit            m_ready;
    bit            iv;
    bit            ordy;
    bit            rd;
    bit            wr;
    logic [DW-1:0] d;
    int            rl;
    int            beats_out;
    int            cycles;
    rl = rl_of(k);
    do_reset();
    for (int i = 0; i < 5; i++) hist[i] = 1'b0;
    m_ovf     = 1'b0;
    beats_out = 0;
    cycles    = 0;
    while (beats_out < n_beats && cycles < 30000) begin
      m_ready = (mq.size() <= DEPTH - 1 - rl);
      chk("rnd_in_ready", ir_v[k], m_ready);
      chk("rnd_out_valid", ov_v[k], mq.size() != 0);
      chk("rnd_occ", occ_v[k], mq.size());
      chk("rnd_overflow", ovf_v[k], m_ovf);
      if (mq.size() != 0) chk("rnd_out_data", od_v[k], mq[0]);
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_ready;
      if (rl == 0) iv = ($urandom_range(1) == 1);
      else         iv = hist[rl] && ($urandom_range(1) == 1);
      ordy = ($urandom_range(1) == 1);
      d    = DW'($urandom);
      rd   = (mq.size() != 0) && ordy;
      if (rl == 0) wr = iv && m_ready;
      else         wr = iv && ((mq.size() < DEPTH) || rd);
      if (rl != 0 && iv && mq.size() == DEPTH && !rd) m_ovf = 1'b1;
      iv_v[k]   = iv;
      id_v[k]   = d;
      ordy_v[k] = ordy;
      step();
      if (rd) begin
        void'(mq.pop_front());
        beats_out++;
      end
      if (wr) mq.push_back(d);
      cycles++;
    end
    chk("rnd_beats_done", beats_out >= n_beats, 1);
    idle_inputs();
  endtask

  logic [DW-1:0] exp_q[$];
  int            exp_occ;
  bit            h1;
  bit            h2;

  initial begin
    reset = 1'b1;
    idle_inputs();

    //                 iv    d         ordy  e_ov  e_od      occ   ir    ovf
    tbl[0]  = '{1'b1, 16'hA001, 1'b0, 1'b1, 16'hA001, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'hA002, 1'b0, 1'b1, 16'hA001, 4'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'hA003, 1'b1, 1'b1, 16'hA003, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'hA004, 1'b0, 1'b1, 16'hA003, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'hA005, 1'b0, 1'b1, 16'hA003, 4'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA003, 4'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA004, 4'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA005, 4'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'hA006, 1'b1, 1'b1, 16'hA006, 4'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0};

    // Table vectors on the zero-latency instance.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      iv_v[0]   = tbl[i].iv;
      id_v[0]   = tbl[i].d;
      ordy_v[0] = tbl[i].ordy;
      step();
      chk("tbl_out_valid", ov_v[0], tbl[i].e_ov);
      if (tbl[i].e_ov) chk("tbl_out_data", od_v[0], tbl[i].e_od);
      chk("tbl_occ", occ_v[0], tbl[i].e_occ);
      chk("tbl_in_ready", ir_v[0], tbl[i].e_ir);
      chk("tbl_overflow", ovf_v[0], tbl[i].e_ovf);
    end

    // Zero latency: fill to 8, in_ready drops, extra beat is ignored.
    for (int i = 0; i < DEPTH; i++) begin
      iv_v[0] = 1'b1; id_v[0] = DW'(16'hB000 + i); ordy_v[0] = 1'b0;
      step();
      chk("rl0_fill_occ", occ_v[0], i + 1);
      chk("rl0_fill_in_ready", ir_v[0], (i + 1) <= DEPTH - 1);
    end
    iv_v[0] = 1'b1; id_v[0] = 16'hBEEF;
    step();
    chk("rl0_ignored_occ", occ_v[0], DEPTH);
    chk("rl0_ignored_overflow", ovf_v[0], 0);
    iv_v[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("rl0_drain_data", od_v[0], 16'hB000 + i);
      ordy_v[0] = 1'b1;
      step();
    end
    chk("rl0_drain_empty", ov_v[0], 0);
    idle_inputs();

    // 20 back-to-back beats with out_ready=1: one-cycle latency, occupancy 1.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      iv_v[0] = 1'b1; id_v[0] = DW'(i); ordy_v[0] = 1'b1;
      step();
      chk("b2b_out_valid", ov_v[0], 1);
      chk("b2b_out_data", od_v[0], i);
      chk("b2b_occ", occ_v[0], 1);
      chk("b2b_overflow", ovf_v[0], 0);
    end
    iv_v[0] = 1'b0;
    step();
    chk("b2b_end_valid", ov_v[0], 0);
    chk("b2b_end_occ", occ_v[0], 0);
    idle_inputs();

    // Latency 2: compliant upstream, in_ready falls at occupancy 6, ends at 8.
    do_reset();
    exp_occ = 0; h1 = 1'b0; h2 = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 14; c++) begin
      chk("rl2_occ", occ_v[2], exp_occ);
      chk("rl2_in_ready", ir_v[2], exp_occ <= 5);
      iv_v[2] = h2; id_v[2] = DW'(16'h0200 + c); ordy_v[2] = 1'b0;
      if (h2) begin
        exp_q.push_back(DW'(16'h0200 + c));
        exp_occ++;
      end
      h2 = h1;
      h1 = ir_v[2];
      step();
    end
    chk("rl2_final_occ", occ_v[2], 8);
    chk("rl2_final_overflow", ovf_v[2], 0);

    // Forced beat into the full buffer: dropped, sticky overflow.
    iv_v[2] = 1'b1; id_v[2] = 16'hDEAD;
    step();
    iv_v[2] = 1'b0;
    chk("ovf_occ", occ_v[2], 8);
    chk("ovf_set", ovf_v[2], 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_sticky", ovf_v[2], 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain_data", od_v[2], exp_q[i]);
      ordy_v[2] = 1'b1;
      step();
    end
    chk("ovf_drain_empty", ov_v[2], 0);
    chk("ovf_drain_occ", occ_v[2], 0);
    chk("ovf_after_drain", ovf_v[2], 1);
    idle_inputs();

    // Full buffer with simultaneous write+read for 10 cycles.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      iv_v[2] = 1'b1; id_v[2] = DW'(16'h0300 + i); ordy_v[2] = 1'b0;
      exp_q.push_back(DW'(16'h0300 + i));
      step();
    end
    chk("wr_rd_full_occ", occ_v[2], 8);
    for (int c = 0; c < 10; c++) begin
      chk("wr_rd_data", od_v[2], exp_q[0]);
      iv_v[2] = 1'b1; id_v[2] = DW'(16'h0310 + c); ordy_v[2] = 1'b1;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(DW'(16'h0310 + c));
      chk("wr_rd_occ", occ_v[2], 8);
      chk("wr_rd_overflow", ovf_v[2], 0);
    end
    iv_v[2] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("wr_rd_drain", od_v[2], exp_q[i]);
      ordy_v[2] = 1'b1;
      step();
    end
    chk("wr_rd_drain_empty", ov_v[2], 0);
    idle_inputs();

    // Reset with 5 beats buffered; a later beat emerges alone.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      iv_v[1] = 1'b1; id_v[1] = DW'(16'h0500 + i); ordy_v[1] = 1'b0;
      step();
    end
    chk("mid_rst_pre_occ", occ_v[1], 5);
    iv_v[1] = 1'b0;
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", ov_v[1], 0);
    chk("mid_rst_occ", occ_v[1], 0);
    chk("mid_rst_overflow", ovf_v[1], 0);
    chk("mid_rst_in_ready", ir_v[1], 0);
    reset = 1'b0;
    step();
    chk("mid_rst_ready_back", ir_v[1], 1);
    iv_v[1] = 1'b1; id_v[1] = 16'h0777;
    step();
    iv_v[1] = 1'b0;
    chk("mid_rst_beat_valid", ov_v[1], 1);
    chk("mid_rst_beat_data", od_v[1], 16'h0777);
    chk("mid_rst_beat_occ", occ_v[1], 1);
    ordy_v[1] = 1'b1;
    step();
    chk("mid_rst_alone_valid", ov_v[1], 0);
    chk("mid_rst_alone_occ", occ_v[1], 0);
    idle_inputs();

    // Randomised traffic on latencies 0, 1 and 4.
    run_random(0, 2500);
    run_random(1, 2500);
    run_random(3, 2500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
